// File: rtl/uart_rx_buffered.sv
// UART 8N1 receiver with 3-sample majority voting and a small receive FIFO.
// The serial input is synchronized first; everything downstream uses only rs_q.
module uart_rx_buffered #(
  parameter int unsigned CLOCKS_PER_PULSE = 5208,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned Half = CLOCKS_PER_PULSE / 2;

  localparam logic [CntW-1:0] CntLast = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CntW-1:0] CntHm1  = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntH    = CntW'(Half);
  localparam logic [CntW-1:0] CntHp1  = CntW'(Half + 1);
  localparam logic [PtrW:0]   DepthV  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

  state_e          state_q, state_d;
  logic            sync_q, rs_q, rs_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            maj, decide, bit_end, push;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            pop, full, wr_en;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  // All reset high so a line idling high never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
    end else begin
      sync_q    <= rx;
      rs_q      <= sync_q;
      rs_prev_q <= rs_q;
    end
  end

  // Majority of the samples at H-1 and H with the live sample at H+1.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rs_q) | (samp_q[1] & rs_q);
  assign decide  = (cnt_q == CntHp1);
  assign bit_end = (cnt_q == CntLast);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (rs_prev_q && !rs_q) state_d = StStart;
      StStart: begin
        if (decide && maj) state_d = StIdle;  // false start
        else if (bit_end)  state_d = StData;
      end
      StData:     if (bit_end && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:     if (decide) state_d = maj ? StIdle : StWaitIdle;
      StWaitIdle: if (rs_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs: push on a good stop bit, error pulse on a bad one.
  always_comb begin
    busy      = (state_q != StIdle);
    push      = (state_q == StStop) && decide && maj;
    frame_err = (state_q == StStop) && decide && !maj;
  end

  // Baud counter, vote samples, shift register and bit index next state.
  always_comb begin
    cnt_d     = cnt_q;
    samp_d    = samp_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;

    // Counter is parked at 0 outside a frame, so entering START restarts it.
    if (state_q == StIdle || state_d == StIdle || state_d == StWaitIdle || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (cnt_q == CntHm1) samp_d[0] = rs_q;
    if (cnt_q == CntH)   samp_d[1] = rs_q;

    if (state_q == StData && decide) shreg_d = {maj, shreg_q[7:1]};

    if (state_q != StData)  bit_idx_d = '0;
    else if (bit_end)       bit_idx_d = bit_idx_q + 1'b1;
  end

  // Receiver datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      samp_q    <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      samp_q    <= samp_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // A pop frees a slot on the same cycle, so a push into a full FIFO still lands.
  assign data_valid = (count_q != '0);
  assign pop        = data_ready && data_valid;
  assign full       = (count_q == DepthVal());
  assign wr_en      = push && (!full || pop);

  function automatic logic [PtrW:0] DepthVal();
    return DepthV;
  endfunction

  // FIFO occupancy next state.
  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overrun flag (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (push && full && !pop) overrun <= 1'b1;
      else if (err_clr)         overrun <= 1'b0;
    end
  end

  // FIFO storage; needs no reset since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign data_out   = data_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;

endmodule
